// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding, default sizes and derived-size helpers for the nibble-serial subtractor
package sub_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_NIBBLE = 4;
    function automatic int nib_count(input int width, input int nibble);
        return width / nibble;
    endfunction
    function automatic int cnt_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sub_nibble.sv
// sub_nibble: combinational NIBBLE-bit subtractor with borrow in/out
module sub_nibble #(
    parameter int NIBBLE = 4
) (
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              bin,
    output logic [NIBBLE-1:0] diff,
    output logic              bout
);
    // One extra bit turns into the borrow: a negative result sets it
    assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{NIBBLE{1'b0}}, bin};
endmodule

// File: rtl/sub_serial_8bit.sv
// sub_serial_8bit: nibble-serial din_one - din_two - bin with valid/ready handshakes
// Optional SUB_SIGNED_OVF_EN adds the signed-overflow output ovf.
module sub_serial_8bit
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NIBBLE = DEF_NIBBLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din_one,
    input  logic [WIDTH-1:0] din_two,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NC = nib_count(WIDTH, NIBBLE);
    localparam int CW = cnt_width(NC);
    if (WIDTH % NIBBLE != 0) begin : g_width_chk
        $error("WIDTH must be a multiple of NIBBLE");
    end
    state_t state, nxt;
    logic [WIDTH-1:0] a, b, diff_nxt;
    logic [CW-1:0] cnt;
    logic borrow, last, nb;
    logic [NIBBLE-1:0] nd;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign last = cnt == CW'(NC - 1);
    // Operands shift down so the active nibble is always at the bottom
    sub_nibble #(.NIBBLE(NIBBLE)) u_nib (
        .a(a[NIBBLE-1:0]),
        .b(b[NIBBLE-1:0]),
        .bin(borrow),
        .diff(nd),
        .bout(nb)
    );
    // Result nibbles enter at the top; after NC shifts nibble 0 lands at the bottom
    assign diff_nxt = (diff >> NIBBLE) | (WIDTH'(nd) << (WIDTH - NIBBLE));
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (in_valid ? CALC : IDLE) :
              state == CALC ? (last ? DONE : CALC) :
              (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a <= '0;
            b <= '0;
            cnt <= '0;
            borrow <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            ovf <= 1'b0;
`endif
        end else if (state == IDLE && in_valid) begin
            a <= din_one;
            b <= din_two;
            borrow <= bin;
            cnt <= '0;
        end else if (state == CALC) begin
            a <= a >> NIBBLE;
            b <= b >> NIBBLE;
            borrow <= nb;
            cnt <= cnt + CW'(1);
            diff <= diff_nxt;
            if (last) begin
                bout <= nb;
`ifdef SUB_SIGNED_OVF_EN
                // On the last nibble the bottom nibble of a/b holds the original MSBs
                ovf <= (a[NIBBLE-1] ^ b[NIBBLE-1]) & (nd[NIBBLE-1] ^ a[NIBBLE-1]);
`endif
            end
        end
endmodule

// File: tb/tb_sub_serial_8bit.sv
// tb_sub_serial_8bit: directed self-checking bench for sub_serial_8bit
module tb_sub_serial_8bit;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, bin, out_valid, out_ready, bout;
    logic [7:0] din_one, din_two, diff;
`ifdef SUB_SIGNED_OVF_EN
    logic ovf;
`endif
    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    sub_serial_8bit dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .din_one(din_one),
        .din_two(din_two),
        .bin(bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff(diff),
        .bout(bout)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .ovf(ovf)
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bi);
        @(negedge clk);
        check("in_ready_before_send", {15'd0, in_ready}, 16'd1);
        in_valid = 1'b1;
        din_one = a;
        din_two = b;
        bin = bi;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic await_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 20);
        if (!out_valid) check("out_valid_timeout", {15'd0, out_valid}, 16'd1);
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("take_out_valid_low", {15'd0, out_valid}, 16'd0);
        check("take_in_ready_high", {15'd0, in_ready}, 16'd1);
    endtask

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input logic [7:0] ed, input logic eb);
        send(a, b, bi);
        await_done(lat);
        check({tag, "_lat"}, 16'(lat), 16'd2);
        check({tag, "_diff"}, {8'd0, diff}, {8'd0, ed});
        check({tag, "_bout"}, {15'd0, bout}, {15'd0, eb});
        take();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        din_one = '0;
        din_two = '0;
        bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_diff", {8'd0, diff}, 16'd0);
        check("rst_bout", {15'd0, bout}, 16'd0);
        rst = 1'b0;

        do_op("basic", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0);
        do_op("wrap", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        do_op("chain", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);

        send(8'hA5, 8'h5A, 1'b0);
        await_done(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_diff", {8'd0, diff}, 16'h004B);
            check("bp_bout", {15'd0, bout}, 16'd0);
            check("bp_in_ready", {15'd0, in_ready}, 16'd0);
            check("bp_out_valid", {15'd0, out_valid}, 16'd1);
            @(posedge clk);
            #1;
        end
        take();

        send(8'h10, 8'h0F, 1'b1);
        in_valid = 1'b1;
        din_one = 8'hFF;
        din_two = 8'h00;
        bin = 1'b0;
        await_done(lat);
        check("busy_lat", 16'(lat), 16'd2);
        check("busy_first_diff", {8'd0, diff}, 16'h0000);
        take();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_accept_in_ready", {15'd0, in_ready}, 16'd0);
        await_done(lat);
        check("busy_second_lat", 16'(lat), 16'd2);
        check("busy_second_diff", {8'd0, diff}, 16'h00FF);
        check("busy_second_bout", {15'd0, bout}, 16'd0);
        take();

        send(8'hA5, 8'h5A, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {15'd0, out_valid}, 16'd0);
        check("arst_diff", {8'd0, diff}, 16'd0);
        check("arst_bout", {15'd0, bout}, 16'd0);
        check("arst_in_ready", {15'd0, in_ready}, 16'd1);
        rst = 1'b0;
        do_op("post_rst", 8'h03, 8'h01, 1'b0, 8'h02, 1'b0);

`ifdef SUB_SIGNED_OVF_EN
        send(8'h80, 8'h01, 1'b0);
        await_done(lat);
        check("ovf1_diff", {8'd0, diff}, 16'h007F);
        check("ovf1_ovf", {15'd0, ovf}, 16'd1);
        take();
        send(8'h7F, 8'h01, 1'b0);
        await_done(lat);
        check("ovf0_diff", {8'd0, diff}, 16'h007E);
        check("ovf0_ovf", {15'd0, ovf}, 16'd0);
        take();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
